dffnrsnq_pipe: RTL

Parametrised, falling-edge-clocked register pipeline: WIDTH-bit data plus a valid bit per stage, DEPTH stages deep, with synchronous active-low reset and set, a global shift enable, and a recirculate mode. It generalises the single-bit negative-edge set/reset flop to a multi-bit, multi-stage structure with occupancy tracking. It sits on falling-edge timing paths in the standard-cell library that need delay lines, retiming or rotating pattern registers.

---
 rtl/dffnrsnq_pipe_if.sv | 19 +
 rtl/dffnrsnq_pipe.sv | 43 ++++
 2 files changed

// File: rtl/dffnrsnq_pipe_if.sv
// dffnrsnq_pipe_if: control, data and status bundle for the falling-edge register pipeline
// Signals: setn (sync active-low set), en (shift enable), mode (0 pipeline, 1 recirculate),
//          d/valid_in (stage 0 input), q/valid_out (last stage), count (valid stages held)
interface dffnrsnq_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       setn;
    logic                       en;
    logic                       mode;
    logic [WIDTH-1:0]           d;
    logic                       valid_in;
    logic [WIDTH-1:0]           q;
    logic                       valid_out;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (output setn, en, mode, d, valid_in, input q, valid_out, count);
    modport slave  (input setn, en, mode, d, valid_in, output q, valid_out, count);
endinterface

// File: rtl/dffnrsnq_pipe.sv
// dffnrsnq_pipe: falling-edge WIDTH x DEPTH register pipeline with sync reset/set and recirculate
// Ports: clkn (falling-edge clock), rn (sync active-low reset), bus (slave side of dffnrsnq_pipe_if)
module dffnrsnq_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input logic            clkn,
    input logic            rn,
    dffnrsnq_pipe_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [CW-1:0]    count;

    always_ff @(negedge clkn) begin
        if (!rn) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
            valid <= '0;
            count <= '0;
        end else if (!bus.setn) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= SET_VAL;
            valid <= '1;
            count <= CW'(DEPTH);
        end else if (bus.en) begin
            for (int i = 1; i < DEPTH; i++) begin
                data[i]  <= data[i-1];
                valid[i] <= valid[i-1];
            end
            data[0]  <= bus.mode ? data[DEPTH-1]  : bus.d;
            valid[0] <= bus.mode ? valid[DEPTH-1] : bus.valid_in;
            // One valid enters and one leaves per shift, so the count stays within 0..DEPTH
            if (!bus.mode) count <= count + CW'(bus.valid_in) - CW'(valid[DEPTH-1]);
        end
    end

    assign bus.q         = data[DEPTH-1];
    assign bus.valid_out = valid[DEPTH-1];
    assign bus.count     = count;
endmodule
